// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared constants, FSM state type and port decode for the 1:4 stream demux
package stream_demux_pkg;
    localparam int N_OUT = 4;
    localparam int SEL_W = 2;
    typedef enum logic {IDLE, PKT} state_t;
    function automatic logic [N_OUT-1:0] onehot4(input logic [SEL_W-1:0] sel);
        return N_OUT'(1) << sel;
    endfunction
endpackage

// File: rtl/stream_demux_out_reg.sv
// stream_demux_out_reg: single-entry valid/ready output slice holding one beat and its destination port
module stream_demux_out_reg
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             last_i,
    input  logic [SEL_W-1:0] dest_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o,
    output logic [SEL_W-1:0] dest_o
);
    logic             vld_q, vld_d, last_q, last_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] dest_q, dest_d;

    always_comb begin
        vld_d  = load_i | (vld_q & ~pop_i);
        data_d = load_i ? data_i : data_q;
        last_d = load_i ? last_i : last_q;
        dest_d = load_i ? dest_i : dest_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
            dest_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            last_q <= last_d;
            dest_q <= dest_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
    assign last_o = last_q;
    assign dest_o = dest_q;
endmodule

// File: rtl/stream_demux_1_4.sv
// stream_demux_1_4: packet-aware 1:4 valid/ready demux; packets to disabled ports are consumed and counted
module stream_demux_1_4
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_last,
    input  logic [N_OUT-1:0] port_en,
    output logic [N_OUT-1:0] out_valid,
    input  logic [N_OUT-1:0] out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [CNT_W-1:0] drop_cnt
);
    state_t           state_q, state_d;
    logic [SEL_W-1:0] lock_sel_q, lock_sel_d, dest, dest_r;
    logic             drop_lock_q, drop_lock_d, drop, vld_r, acc, pop;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Routing and drop decision come from the live inputs only on a first beat.
    assign dest     = (state_q == PKT) ? lock_sel_q : in_sel;
    assign drop     = (state_q == PKT) ? drop_lock_q : ~port_en[in_sel];
    assign pop      = vld_r & out_ready[dest_r];
    assign in_ready = drop | ~vld_r | out_ready[dest_r];
    assign acc      = in_valid & in_ready;

    stream_demux_out_reg #(.WIDTH(WIDTH)) u_out_reg (
        .clk    (clk),
        .rst    (rst),
        .load_i (acc & ~drop),
        .pop_i  (pop),
        .data_i (in_data),
        .last_i (in_last),
        .dest_i (dest),
        .vld_o  (vld_r),
        .data_o (out_data),
        .last_o (out_last),
        .dest_o (dest_r)
    );

    always_comb begin
        state_d     = state_q;
        lock_sel_d  = lock_sel_q;
        drop_lock_d = drop_lock_q;
        drop_cnt_d  = drop_cnt_q;
        if (acc) begin
            if (state_q == IDLE && !in_last) begin
                state_d     = PKT;
                lock_sel_d  = in_sel;
                drop_lock_d = ~port_en[in_sel];
            end
            if (state_q == PKT && in_last) state_d = IDLE;
            if (drop && in_last && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lock_sel_q  <= '0;
            drop_lock_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            lock_sel_q  <= lock_sel_d;
            drop_lock_q <= drop_lock_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_valid = vld_r ? onehot4(dest_r) : '0;
    assign drop_cnt  = drop_cnt_q;
endmodule
